// File: rtl/limb_div64by32_seq_if.sv
// Operand/result handshake bundle for limb_div64by32_seq.
// The abort input is present only when DIV_ABORT_EN is defined.
interface limb_div64by32_seq_if #(
  parameter int LIMB_W = 16
);
  logic              in_valid;
  logic              in_ready;
  logic [LIMB_W-1:0] y3, y2, y1, y0;
  logic [LIMB_W-1:0] b1, b0;
  logic              out_valid;
  logic              out_ready;
  logic [LIMB_W-1:0] q1, q0;
  logic [LIMB_W-1:0] rem1, rem0;
  logic              div_by_zero;
  logic              overflow;
`ifdef DIV_ABORT_EN
  logic              abort;

  modport master (
    output in_valid, y3, y2, y1, y0, b1, b0, out_ready, abort,
    input  in_ready, out_valid, q1, q0, rem1, rem0, div_by_zero, overflow
  );

  modport slave (
    input  in_valid, y3, y2, y1, y0, b1, b0, out_ready, abort,
    output in_ready, out_valid, q1, q0, rem1, rem0, div_by_zero, overflow
  );
`else
  modport master (
    output in_valid, y3, y2, y1, y0, b1, b0, out_ready,
    input  in_ready, out_valid, q1, q0, rem1, rem0, div_by_zero, overflow
  );

  modport slave (
    input  in_valid, y3, y2, y1, y0, b1, b0, out_ready,
    output in_ready, out_valid, q1, q0, rem1, rem0, div_by_zero, overflow
  );
`endif
endinterface

// File: rtl/limb_div64by32_seq.sv
// Sequential restoring divider: {y3,y2,y1,y0} / {b1,b0} -> {q1,q0}, {rem1,rem0}.
// Optional abort input enabled by defining DIV_ABORT_EN.
module limb_div64by32_seq #(
  parameter int LIMB_W         = 16,
  parameter int ITER_PER_CYCLE = 1
) (
  input logic                 clk,
  input logic                 rst_n,
  limb_div64by32_seq_if.slave bus
);
  localparam int DW    = 2 * LIMB_W;
  localparam int N     = DW / ITER_PER_CYCLE;
  localparam int CNT_W = $clog2(N) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [DW-1:0]    ALL_ZERO = {DW{1'b0}};
  localparam logic [DW-1:0]    ALL_ONES = {DW{1'b1}};

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CHECK = 2'd1,
    S_RUN   = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  state_e           state_r, state_s;
  logic [DW-1:0]    pr_r,  pr_s;   // partial remainder
  logic [DW-1:0]    sh_r,  sh_s;   // low dividend bits out at the top, quotient bits in at the bottom
  logic [DW-1:0]    dvs_r, dvs_s;
  logic [CNT_W-1:0] cnt_r, cnt_s;
  logic [DW-1:0]    q_r,   q_s;
  logic [DW-1:0]    rem_r, rem_s;
  logic             dz_r,  dz_s;
  logic             ovf_r, ovf_s;
  logic             ov_r,  ov_s;
  logic             ir_r,  ir_s;
  logic [DW-1:0]    step_pr_s, step_sh_s;
  logic             abort_s;

`ifdef DIV_ABORT_EN
  assign abort_s = bus.abort;
`else
  assign abort_s = 1'b0;
`endif

  // One restoring step; the DW+1-bit difference's top bit is the borrow, since pr < divisor.
  function automatic logic [2*DW-1:0] div_step(
    input logic [DW-1:0] pr,
    input logic [DW-1:0] sh,
    input logic [DW-1:0] dvs
  );
    logic [DW:0] trial;
    logic [DW:0] diff;
    trial = {pr, sh[DW-1]};
    diff  = trial - {1'b0, dvs};
    if (diff[DW]) begin
      div_step = {trial[DW-1:0], sh[DW-2:0], 1'b0};
    end else begin
      div_step = {diff[DW-1:0], sh[DW-2:0], 1'b1};
    end
  endfunction

  // Resolve ITER_PER_CYCLE quotient bits from the current partial remainder.
  always_comb begin
    step_pr_s = pr_r;
    step_sh_s = sh_r;
    for (int i = 0; i < ITER_PER_CYCLE; i++) begin
      {step_pr_s, step_sh_s} = div_step(step_pr_s, step_sh_s, dvs_r);
    end
  end

  // Next-state and next-datapath decode.
  always_comb begin
    state_s = state_r;
    pr_s    = pr_r;
    sh_s    = sh_r;
    dvs_s   = dvs_r;
    cnt_s   = cnt_r;
    q_s     = q_r;
    rem_s   = rem_r;
    dz_s    = dz_r;
    ovf_s   = ovf_r;
    ov_s    = ov_r;
    ir_s    = ir_r;
    case (state_r)
      S_IDLE: begin
        if (bus.in_valid) begin
          state_s = S_CHECK;
          pr_s    = {bus.y3, bus.y2};
          sh_s    = {bus.y1, bus.y0};
          dvs_s   = {bus.b1, bus.b0};
          ir_s    = 1'b0;
        end else begin
          ir_s    = 1'b1;
        end
      end
      S_CHECK: begin
        if (abort_s) begin
          state_s = S_IDLE;
          pr_s    = ALL_ZERO;
          sh_s    = ALL_ZERO;
          dvs_s   = ALL_ZERO;
          cnt_s   = CNT_ZERO;
          ir_s    = 1'b1;
        end else if (dvs_r == ALL_ZERO) begin
          state_s = S_DONE;
          dz_s    = 1'b1;
          q_s     = ALL_ONES;
          rem_s   = sh_r;
          ov_s    = 1'b1;
        end else if (pr_r >= dvs_r) begin
          state_s = S_DONE;
          ovf_s   = 1'b1;
          q_s     = ALL_ONES;
          rem_s   = ALL_ZERO;
          ov_s    = 1'b1;
        end else begin
          state_s = S_RUN;
          cnt_s   = CNT_ZERO;
        end
      end
      S_RUN: begin
        if (abort_s) begin
          state_s = S_IDLE;
          pr_s    = ALL_ZERO;
          sh_s    = ALL_ZERO;
          dvs_s   = ALL_ZERO;
          cnt_s   = CNT_ZERO;
          ir_s    = 1'b1;
        end else begin
          pr_s = step_pr_s;
          sh_s = step_sh_s;
          if (cnt_r == CNT_LAST) begin
            state_s = S_DONE;
            q_s     = step_sh_s;
            rem_s   = step_pr_s;
            ov_s    = 1'b1;
            cnt_s   = CNT_ZERO;
          end else begin
            cnt_s   = cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
          end
        end
      end
      S_DONE: begin
        if (bus.out_ready) begin
          state_s = S_IDLE;
          ov_s    = 1'b0;
          dz_s    = 1'b0;
          ovf_s   = 1'b0;
          ir_s    = 1'b1;
        end else begin
          state_s = S_DONE;
        end
      end
      default: begin
        state_s = S_IDLE;
        ov_s    = 1'b0;
        ir_s    = 1'b1;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Datapath and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pr_r  <= ALL_ZERO;
      sh_r  <= ALL_ZERO;
      dvs_r <= ALL_ZERO;
      cnt_r <= CNT_ZERO;
      q_r   <= ALL_ZERO;
      rem_r <= ALL_ZERO;
      dz_r  <= 1'b0;
      ovf_r <= 1'b0;
      ov_r  <= 1'b0;
      ir_r  <= 1'b1;
    end else begin
      pr_r  <= pr_s;
      sh_r  <= sh_s;
      dvs_r <= dvs_s;
      cnt_r <= cnt_s;
      q_r   <= q_s;
      rem_r <= rem_s;
      dz_r  <= dz_s;
      ovf_r <= ovf_s;
      ov_r  <= ov_s;
      ir_r  <= ir_s;
    end
  end

  assign bus.in_ready    = ir_r;
  assign bus.out_valid   = ov_r;
  assign bus.q1          = q_r[DW-1:LIMB_W];
  assign bus.q0          = q_r[LIMB_W-1:0];
  assign bus.rem1        = rem_r[DW-1:LIMB_W];
  assign bus.rem0        = rem_r[LIMB_W-1:0];
  assign bus.div_by_zero = dz_r;
  assign bus.overflow    = ovf_r;

endmodule
